// File: rtl/p2s_ser.sv
// p2s_ser - parallel-to-serial framer.
//
// Accepts BIT-wide words through a valid/ready handshake into a one-word
// holding register, then shifts each word out MSB first on dext, one bit per
// clock. A word waiting in the holding register is loaded into the shifter on
// the same edge the previous word's LSB finishes, so back-to-back words form
// a gap-free stream of BIT-bit frames.
//
// Parameters:
//   BIT         parallel word width and number of bits per serial frame
//   IDLE_LEVEL  level driven on dext while no word is being shifted
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   din        parallel word offered for transfer
//   din_valid  din holds a word offered for transfer
//   din_ready  block can accept a word on the coming edge
//   dext       registered serial output, MSB first
//   frame      registered, high while dext carries the MSB of a word
//   busy       high while the shifter holds a word
module p2s_ser #(
    parameter int   BIT        = 10,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [BIT-1:0] din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic           dext,
    output logic           frame,
    output logic           busy
);

    localparam int             CW       = (BIT > 1) ? $clog2(BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(BIT - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state, state_nxt;
    logic [BIT-1:0] hold, hold_nxt;
    logic           hold_full, hold_full_nxt;
    logic [BIT-1:0] shreg, shreg_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           dext_nxt;
    logic           frame_nxt;
    logic           xfer;
    logic           accept;

    // The held word moves into the shifter whenever the shifter is empty or
    // is emitting its last bit this cycle. Because xfer is built only from
    // registers, din_ready never combinationally depends on din_valid.
    assign xfer      = hold_full && ((state == IDLE) || (cnt == CNT_LAST));
    assign din_ready = !hold_full || xfer;
    assign accept    = din_valid && din_ready;
    assign busy      = (state == SHIFT);

    // Holding register next-state. An accept on the same edge as an xfer
    // wins, so the freshly accepted word stays held while the old one moves
    // into the shifter.
    always_comb begin
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        if (accept) begin
            hold_nxt      = din;
            hold_full_nxt = 1'b1;
        end else if (xfer) begin
            hold_full_nxt = 1'b0;
        end
    end

    // Shifter state machine next-state and registered outputs. dext always
    // shows the MSB of the shifter contents after the edge, so loading
    // presents bit BIT-1 immediately and each left shift exposes the next bit.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        dext_nxt  = IDLE_LEVEL;
        frame_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = SHIFT;
                    shreg_nxt = hold;
                    cnt_nxt   = '0;
                    dext_nxt  = hold[BIT-1];
                    frame_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    if (xfer) begin
                        shreg_nxt = hold;
                        cnt_nxt   = '0;
                        dext_nxt  = hold[BIT-1];
                        frame_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    shreg_nxt = shreg << 1;
                    cnt_nxt   = cnt + CW'(1);
                    dext_nxt  = shreg_nxt[BIT-1];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register. Reset drops both the word in the shifter and the held
    // word, and returns dext to the idle level without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            dext      <= IDLE_LEVEL;
            frame     <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            dext      <= dext_nxt;
            frame     <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_p2s_ser.sv
// tb_p2s_ser - directed self-checking bench for p2s_ser (BIT=10,
// IDLE_LEVEL=0). Covers reset behaviour, a single word, back-to-back words,
// backpressure with four queued words, reset in the middle of a word, and a
// loopback receiver that reassembles frames from dext.
module tb_p2s_ser;

    localparam int BIT = 10;

    logic           clk;
    logic           rst_n;
    logic [BIT-1:0] din;
    logic           din_valid;
    logic           din_ready;
    logic           dext;
    logic           frame;
    logic           busy;

    int assertCount = 0;
    int failCount   = 0;

    p2s_ser #(
        .BIT        (BIT),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dext      (dext),
        .frame     (frame),
        .busy      (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case something upstream stalls the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge, where outputs are sampled
    // and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the handshake inputs for the next edge.
    task automatic applyStimulus(input logic valid, input logic [BIT-1:0] data);
        din_valid = valid;
        din       = data;
    endtask

    // One comparison point: counts the assertion and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [BIT-1:0]   word;
        logic [2*BIT-1:0] pair;
        logic [BIT-1:0]   words [4];
        logic [BIT-1:0]   got   [4];
        logic [BIT-1:0]   rx;
        int n, hs, stalls, nbits, frames, bitIdx, cyc;

        // ---------------- reset with din_valid held high ----------------
        rst_n = 1'b0;
        applyStimulus(1'b1, 10'h3FF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst dext c%0d", i), 32'(dext), 32'd0);
            checkOutput($sformatf("rst frame c%0d", i), 32'(frame), 32'd0);
            checkOutput($sformatf("rst busy c%0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("rst din_ready c%0d", i), 32'(din_ready), 32'd1);
        end
        applyStimulus(1'b0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("post-rst busy c%0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("post-rst dext c%0d", i), 32'(dext), 32'd0);
        end

        // ---------------- single word ----------------
        word = 10'b1011001110;
        applyStimulus(1'b1, word);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("single busy after accept", 32'(busy), 32'd0);
        for (int j = 1; j <= BIT; j++) begin
            tick();
            checkOutput($sformatf("single dext b%0d", j), 32'(dext), 32'(word[BIT-j]));
            checkOutput($sformatf("single frame b%0d", j), 32'(frame), 32'(j == 1));
            checkOutput($sformatf("single busy b%0d", j), 32'(busy), 32'd1);
        end
        tick();
        checkOutput("single dext idle", 32'(dext), 32'd0);
        checkOutput("single busy idle", 32'(busy), 32'd0);
        checkOutput("single frame idle", 32'(frame), 32'd0);

        // ---------------- back-to-back words ----------------
        pair = {10'h3A5, 10'h0F0};
        applyStimulus(1'b1, 10'h3A5);
        tick();
        applyStimulus(1'b1, 10'h0F0);
        tick();
        applyStimulus(1'b0, '0);
        for (int j = 1; j <= 2*BIT; j++) begin
            if (j > 1) tick();
            checkOutput($sformatf("b2b dext b%0d", j), 32'(dext), 32'(pair[2*BIT-j]));
            checkOutput($sformatf("b2b frame b%0d", j), 32'(frame), 32'((j == 1) || (j == 11)));
            checkOutput($sformatf("b2b busy b%0d", j), 32'(busy), 32'd1);
        end
        tick();
        checkOutput("b2b busy idle", 32'(busy), 32'd0);
        checkOutput("b2b dext idle", 32'(dext), 32'd0);

        // ---------------- backpressure with four words ----------------
        // First word goes straight into the empty hold, the second rides the
        // xfer edge, then each later word waits 9 cycles for the hold to free.
        words[0] = 10'h3C1;
        words[1] = 10'h0A5;
        words[2] = 10'h2F0;
        words[3] = 10'h11E;
        for (int i = 0; i < 4; i++) got[i] = '0;
        n = 0; hs = 0; stalls = 0; nbits = 0; rx = '0; cyc = 0;
        while ((cyc < 120) && (nbits < 4*BIT)) begin
            if (n < 4) begin
                applyStimulus(1'b1, words[n]);
                if (din_ready) begin
                    hs++;
                    n++;
                end else begin
                    stalls++;
                end
            end else begin
                applyStimulus(1'b0, '0);
            end
            tick();
            cyc++;
            if (busy) begin
                checkOutput($sformatf("bp frame bit%0d", nbits), 32'(frame),
                            32'((nbits % BIT) == 0));
                rx = {rx[BIT-2:0], dext};
                nbits++;
                if ((nbits % BIT) == 0) got[nbits/BIT - 1] = rx;
            end
        end
        applyStimulus(1'b0, '0);
        checkOutput("bp bits emitted", 32'(nbits), 32'(4*BIT));
        checkOutput("bp handshakes", 32'(hs), 32'd4);
        checkOutput("bp stall cycles", 32'(stalls), 32'd18);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("bp word%0d", i), 32'(got[i]), 32'(words[i]));
        tick();
        checkOutput("bp busy idle", 32'(busy), 32'd0);

        // ---------------- reset in the middle of a word ----------------
        word = 10'h2AA;
        applyStimulus(1'b1, word);
        tick();
        applyStimulus(1'b1, 10'h155);
        tick();
        applyStimulus(1'b0, '0);
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) tick();
            checkOutput($sformatf("midrst dext b%0d", j), 32'(dext), 32'(word[BIT-j]));
        end
        checkOutput("midrst hold full", 32'(din_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst dext immediate", 32'(dext), 32'd0);
        checkOutput("midrst busy immediate", 32'(busy), 32'd0);
        checkOutput("midrst frame immediate", 32'(frame), 32'd0);
        checkOutput("midrst din_ready", 32'(din_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("midrst after busy c%0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("midrst after dext c%0d", i), 32'(dext), 32'd0);
        end

        // ---------------- loopback receiver ----------------
        // A small serial receiver starts a frame on the frame pulse and
        // rebuilds the word from the following BIT samples of dext.
        applyStimulus(1'b1, 10'h1C7);
        frames = 0; bitIdx = -1; rx = '0; cyc = 0;
        while ((cyc < 60) && (frames < 3)) begin
            tick();
            cyc++;
            if (frame) begin
                bitIdx = 0;
                rx     = '0;
            end
            if (bitIdx >= 0) begin
                rx = {rx[BIT-2:0], dext};
                bitIdx++;
                if (bitIdx == BIT) begin
                    checkOutput($sformatf("loop frame%0d", frames), 32'(rx), 32'h1C7);
                    frames++;
                    bitIdx = -1;
                end
            end
        end
        applyStimulus(1'b0, '0);
        checkOutput("loop frames received", 32'(frames), 32'd3);
        cyc = 0;
        while ((cyc < 40) && busy) begin
            tick();
            cyc++;
        end
        checkOutput("loop drain busy", 32'(busy), 32'd0);
        checkOutput("loop drain dext", 32'(dext), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/p2s_ser.md
P2S_SER -- requirements
Module: p2s_ser

Interface
REQ-001 Parameter: BIT, default 10, parallel word width and bits per serial frame.
REQ-002 Parameter: IDLE_LEVEL, default 0, level driven on dext when no word is being shifted.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: din  input  BIT  parallel word to serialize.
REQ-006 Port: din_valid  input  1  din holds a word offered for transfer.
REQ-007 Port: din_ready  output  1  block can accept a word this cycle.
REQ-008 Port: dext  output  1  registered serial output, MSB first, one bit per clk; feeds the s2p serial input.
REQ-009 Port: frame  output  1  registered; high exactly while dext carries bit BIT-1 (MSB) of a word.
REQ-010 Port: busy  output  1  high while the shifter holds a word (state SHIFT).

Function
REQ-011 Handshake: a word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; no other edge accepts.
REQ-012 Storage: one holding register (hold, hold_full) plus one shift register with bit counter cnt (0..BIT-1).
REQ-013 din_ready SHALL equal !hold_full || xfer, where xfer = hold moving to shifter this edge; it SHALL depend only on registers, never on din_valid.
REQ-014 State machine, two states: IDLE (shifter empty), SHIFT (word in shifter).
REQ-015 IDLE: if hold_full, SHALL load shifter from hold (xfer=1), set cnt=0, and go to SHIFT; else stay IDLE.
REQ-016 SHIFT: each edge SHALL advance one bit and increment cnt; dext = shifter bit BIT-1-cnt.
REQ-017 SHIFT at cnt=BIT-1: if hold_full, SHALL reload from hold (xfer=1), set cnt=0, and stay in SHIFT, with no idle gap between words; else SHALL go to IDLE.
REQ-018 Latency: a word accepted at edge k into an empty block SHALL appear as MSB on dext after edge k+1; its LSB SHALL appear after edge k+BIT.
REQ-019 Back-to-back: if a word is continuously available, dext SHALL emit a contiguous stream of BIT-bit frames.
REQ-020 Simultaneous accept and xfer on the same edge SHALL leave hold_full=1 with the new word.
REQ-021 A word SHALL never be overwritten, dropped, or duplicated.
REQ-022 In IDLE: dext=IDLE_LEVEL, frame=0, busy=0.
REQ-023 din is sampled only on the accepting edge; later changes to din SHALL NOT affect the shifted word.
REQ-024 cnt width: ceil(log2(BIT)); cnt SHALL NOT pass BIT-1.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, hold_full=0, cnt=0, shifter=0, dext=IDLE_LEVEL, frame=0, busy=0.
REQ-026 While rst_n=0, din_ready SHALL be 1, and no word is accepted.
REQ-027 Reset asserted mid-word SHALL discard both the shifter word and the held word, and SHALL return dext to IDLE_LEVEL in the same cycle.
REQ-028 After rst_n deasserts, the first accepting edge is the first rising edge with rst_n=1.

Verification
REQ-029 Reset: rst_n=0 for 3 cycles with din_valid=1 -> dext=0, frame=0, busy=0, din_ready=1, nothing emitted after release until a new accept.
REQ-030 Single word: din=10'b1011001110 accepted at edge k -> dext after edges k+1..k+10 = 1,0,1,1,0,0,1,1,1,0; frame=1 only after k+1; busy 1 for 10 cycles; then dext=0.
REQ-031 Back-to-back: 10'h3A5 then 10'h0F0 with din_valid held -> 20 contiguous bits; frame high at bit 0 and bit 10; no gap; busy continuously 1.
REQ-032 Backpressure: din_valid held high with 4 distinct words -> din_ready low while hold is full; each word emitted exactly once, in order; handshake count = 4.
REQ-033 Mid-word reset: assert rst_n=0 after bit 4 of 10'h2AA while a second word is held -> dext=0 immediately; after release with no new input, no further bits and busy=0.
REQ-034 Loopback: p2s_ser dext drives s2p dext with 10'h1C7 sent repeatedly -> s2p dout equals 10'h1C7 at every frame boundary (sampled when frame is observed 10 cycles later).
